// File: rtl/amo_unit.sv
// RV64A atomic execute unit: sequences LR / SC / AMO read-modify-write against a
// single data-memory port and owns the one LR/SC reservation.
module amo_unit #(
  parameter int RESV_GRAN_LOG2 = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_funct5,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_rs2,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [1:0]  mem_size,
  output logic [63:0] mem_wdata,
  input  logic        mem_rsp_valid,
  input  logic [63:0] mem_rdata,
  input  logic        resv_clear,
  output logic        rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RESP} state_t;

  localparam logic [4:0] F_LR   = 5'b00010;
  localparam logic [4:0] F_SC   = 5'b00011;
  localparam logic [4:0] F_SWAP = 5'b00001;
  localparam logic [4:0] F_ADD  = 5'b00000;
  localparam logic [4:0] F_XOR  = 5'b00100;
  localparam logic [4:0] F_AND  = 5'b01100;
  localparam logic [4:0] F_OR   = 5'b01000;
  localparam logic [4:0] F_MIN  = 5'b10000;
  localparam logic [4:0] F_MAX  = 5'b10100;
  localparam logic [4:0] F_MINU = 5'b11000;
  localparam logic [4:0] F_MAXU = 5'b11100;

  state_t      state;
  logic [4:0]  funct5_q;
  logic        is_w_q;
  logic [63:0] addr_q;
  logic [63:0] rs2_q;
  logic [63:0] wdata_q;
  logic [63:0] rdata_q;
  logic [1:0]  size_q;
  logic [1:0]  err_q;
  logic        resv_valid;
  logic [63:RESV_GRAN_LOG2] resv_addr;

  logic        f5_legal, f3_legal, misaligned, resv_hit, req_is_w;
  logic [63:0] a_u, b_u, a_s, b_s, alu_res, amo_res, old_ext;
  logic        lt_s, lt_u;

  // Both handshakes are plain valid/ready: a transfer happens on a clock edge where
  // valid and ready are both high; a valid request holds its payload stable until then.
  assign req_ready     = (state == IDLE);
  assign mem_req_valid = (state == RD_REQ) || (state == WR_REQ);
  assign mem_we        = (state == WR_REQ);
  assign mem_addr      = addr_q;
  assign mem_size      = size_q;
  assign mem_wdata     = wdata_q;
  assign rsp_valid     = (state == RESP);
  assign rsp_rdata     = rdata_q;
  assign rsp_err       = err_q;
  assign dbg_state     = state;

  assign req_is_w   = (req_funct3 == 3'b010);
  assign f3_legal   = req_is_w || (req_funct3 == 3'b011);
  assign misaligned = req_is_w ? (|req_addr[1:0]) : (|req_addr[2:0]);
  // A clear arriving with the SC is treated as having already invalidated it.
  assign resv_hit   = resv_valid && !resv_clear &&
                      (resv_addr == req_addr[63:RESV_GRAN_LOG2]);

  always_comb begin
    case (req_funct5)
      F_LR, F_SC, F_SWAP, F_ADD, F_XOR, F_AND,
      F_OR, F_MIN, F_MAX, F_MINU, F_MAXU: f5_legal = 1'b1;
      default:                            f5_legal = 1'b0;
    endcase
  end

  // Word ops see zero-extended operands for arithmetic and sign-extended ones for signed compares.
  always_comb begin
    a_u  = is_w_q ? {32'b0, mem_rdata[31:0]} : mem_rdata;
    b_u  = is_w_q ? {32'b0, rs2_q[31:0]} : rs2_q;
    a_s  = is_w_q ? {{32{mem_rdata[31]}}, mem_rdata[31:0]} : mem_rdata;
    b_s  = is_w_q ? {{32{rs2_q[31]}}, rs2_q[31:0]} : rs2_q;
    lt_s = $signed(a_s) < $signed(b_s);
    lt_u = a_u < b_u;
    case (funct5_q)
      F_ADD:   alu_res = a_u + b_u;
      F_XOR:   alu_res = a_u ^ b_u;
      F_AND:   alu_res = a_u & b_u;
      F_OR:    alu_res = a_u | b_u;
      F_MIN:   alu_res = lt_s ? a_u : b_u;
      F_MAX:   alu_res = lt_s ? b_u : a_u;
      F_MINU:  alu_res = lt_u ? a_u : b_u;
      F_MAXU:  alu_res = lt_u ? b_u : a_u;
      default: alu_res = b_u;
    endcase
    amo_res = is_w_q ? {32'b0, alu_res[31:0]} : alu_res;
    old_ext = a_s;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      funct5_q   <= '0;
      is_w_q     <= 1'b0;
      addr_q     <= '0;
      rs2_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      size_q     <= '0;
      err_q      <= '0;
      resv_valid <= 1'b0;
      resv_addr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            funct5_q <= req_funct5;
            is_w_q   <= req_is_w;
            addr_q   <= req_addr;
            rs2_q    <= req_rs2;
            size_q   <= req_funct3[1:0];
            err_q    <= 2'b00;
            if (!f3_legal || !f5_legal) begin
              err_q   <= 2'b01;
              rdata_q <= '0;
              state   <= RESP;
            end else if (misaligned) begin
              err_q   <= 2'b10;
              rdata_q <= '0;
              state   <= RESP;
            end else if (req_funct5 == F_SC) begin
              resv_valid <= 1'b0;
              if (resv_hit) begin
                wdata_q <= req_is_w ? {32'b0, req_rs2[31:0]} : req_rs2;
                rdata_q <= '0;
                state   <= WR_REQ;
              end else begin
                rdata_q <= 64'd1;
                state   <= RESP;
              end
            end else begin
              state <= RD_REQ;
            end
          end
        end
        RD_REQ:  if (mem_req_ready) state <= RD_WAIT;
        RD_WAIT: begin
          if (mem_rsp_valid) begin
            rdata_q <= old_ext;
            if (funct5_q == F_LR) begin
              resv_valid <= 1'b1;
              resv_addr  <= addr_q[63:RESV_GRAN_LOG2];
              state      <= RESP;
            end else begin
              wdata_q <= amo_res;
              state   <= WR_REQ;
            end
          end
        end
        WR_REQ:  if (mem_req_ready) state <= WR_WAIT;
        WR_WAIT: if (mem_rsp_valid) state <= RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      // Last assignment so an invalidate beats a reservation set in the same cycle.
      if (resv_clear) resv_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_amo_unit.sv
// Directed bench for amo_unit: a small memory responder with stall/delay knobs
// and hand-computed expectations for every operation.
module tb_amo_unit;

  localparam logic [4:0] F_LR   = 5'b00010;
  localparam logic [4:0] F_SC   = 5'b00011;
  localparam logic [4:0] F_SWAP = 5'b00001;
  localparam logic [4:0] F_ADD  = 5'b00000;
  localparam logic [4:0] F_XOR  = 5'b00100;
  localparam logic [4:0] F_AND  = 5'b01100;
  localparam logic [4:0] F_OR   = 5'b01000;
  localparam logic [4:0] F_MIN  = 5'b10000;
  localparam logic [4:0] F_MAX  = 5'b10100;
  localparam logic [4:0] F_MINU = 5'b11000;
  localparam logic [4:0] F_MAXU = 5'b11100;
  localparam logic [2:0] FW = 3'b010;
  localparam logic [2:0] FD = 3'b011;

  logic        clk, rst_n;
  logic        req_valid, req_ready;
  logic [4:0]  req_funct5;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr, req_rs2;
  logic        mem_req_valid, mem_req_ready, mem_we;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_size;
  logic        mem_rsp_valid, resv_clear;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic [2:0]  dbg_state;

  amo_unit #(.RESV_GRAN_LOG2(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_funct5(req_funct5), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_rs2(req_rs2),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_size(mem_size),
    .mem_wdata(mem_wdata), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .resv_clear(resv_clear),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mem [logic [63:0]];

  // responder state (written only by the responder processes)
  int          cyc = 0;
  int          due = -1;
  int          rd_cnt = 0, wr_cnt = 0;
  int          stall_used = 0, stall_checks = 0, stall_bad = 0;
  logic [63:0] pend_data = '0;
  logic [63:0] last_rd_addr = '0, last_wr_addr = '0, last_wr_data = '0;
  logic [1:0]  last_wr_size = '0;
  logic        prev_stall = 1'b0, prev_we = 1'b0;
  logic [63:0] prev_addr = '0, prev_wdata = '0;
  logic [1:0]  prev_size = '0;

  // test knobs (written only by the main initial block)
  int stall_req = 0;
  int rsp_delay = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (prev_stall) begin
      stall_checks++;
      if (!(mem_req_valid && mem_addr == prev_addr && mem_we == prev_we &&
            mem_wdata == prev_wdata && mem_size == prev_size))
        stall_bad++;
    end
    prev_stall = rst_n && mem_req_valid && !mem_req_ready;
    prev_addr  = mem_addr;
    prev_we    = mem_we;
    prev_wdata = mem_wdata;
    prev_size  = mem_size;
    if (rst_n && mem_req_valid && mem_req_ready) begin
      due = cyc + rsp_delay;
      if (mem_we) begin
        wr_cnt++;
        last_wr_addr = mem_addr;
        last_wr_data = mem_wdata;
        last_wr_size = mem_size;
      end else begin
        rd_cnt++;
        last_rd_addr = mem_addr;
        pend_data = mem.exists(mem_addr) ? mem[mem_addr] : 64'd0;
      end
    end
  end

  always @(negedge clk) begin
    if (mem_req_valid && stall_used < stall_req) begin
      mem_req_ready = 1'b0;
      stall_used++;
    end else begin
      mem_req_ready = 1'b1;
    end
    mem_rsp_valid = (cyc == due);
    mem_rdata = mem_rsp_valid ? pend_data : 64'hDEAD_BEEF_DEAD_BEEF;
  end

  // driver: present one op and wait (bounded) for the response pulse
  task automatic do_op(input logic [4:0] f5, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] r2, input int clr_cyc,
                       output int lat, output logic [63:0] rd, output logic [1:0] err);
    lat = -1; rd = '0; err = '0;
    @(negedge clk);
    check("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_funct5 = f5; req_funct3 = f3; req_addr = a; req_rs2 = r2;
    resv_clear = (clr_cyc == 0);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      req_valid  = 1'b0;
      resv_clear = (clr_cyc == c);
      if (rsp_valid) begin
        lat = c; rd = rsp_rdata; err = rsp_err;
        break;
      end
    end
    resv_clear = 1'b0;
  endtask

  task automatic run(input string tag, input logic [4:0] f5, input logic [2:0] f3,
                     input logic [63:0] a, input logic [63:0] r2, input int clr_cyc,
                     input int e_lat, input logic [63:0] e_rd, input logic [1:0] e_err,
                     input int e_rd_n, input int e_wr_n);
    int lat, r0, w0;
    logic [63:0] rd;
    logic [1:0]  err;
    r0 = rd_cnt; w0 = wr_cnt;
    do_op(f5, f3, a, r2, clr_cyc, lat, rd, err);
    check({tag, "_lat"}, 64'(lat), 64'(e_lat));
    check({tag, "_rd"}, rd, e_rd);
    check({tag, "_err"}, 64'(err), 64'(e_err));
    check({tag, "_nreads"}, 64'(rd_cnt - r0), 64'(e_rd_n));
    check({tag, "_nwrites"}, 64'(wr_cnt - w0), 64'(e_wr_n));
    if (rd_cnt != r0) check({tag, "_rd_addr"}, last_rd_addr, a);
    if (wr_cnt != w0 && exp_q.size() > 0) begin
      check({tag, "_wdata"}, last_wr_data, exp_q.pop_front());
      check({tag, "_wr_addr"}, last_wr_addr, a);
      check({tag, "_wr_size"}, 64'(last_wr_size), (f3 == FW) ? 64'd2 : 64'd3);
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_funct5 = '0; req_funct3 = '0;
    req_addr = '0; req_rs2 = '0; resv_clear = 1'b0;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    check("rst_mem_wdata", mem_wdata, 64'd0);
    check("rst_mem_size", 64'(mem_size), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", rsp_rdata, 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);

    // AMOs: preload, queue expected write data, run
    mem[64'h100] = 64'd5;
    exp_q.push_back(64'd12);
    run("amoadd_d", F_ADD, FD, 64'h100, 64'd7, -1, 5, 64'd5, 2'b00, 1, 1);
    mem[64'h110] = 64'h0000_0000_FFFF_FFFF;
    exp_q.push_back(64'h0000_0000_FFFF_FFFF);
    run("amomin_w", F_MIN, FW, 64'h110, 64'd1, -1, 5, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1, 1);
    mem[64'h118] = 64'h0000_0000_FFFF_FFFF;
    exp_q.push_back(64'd1);
    run("amominu_w", F_MINU, FW, 64'h118, 64'd1, -1, 5, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1, 1);
    mem[64'h120] = 64'h0000_0000_7FFF_FFFF;
    exp_q.push_back(64'h0000_0000_8000_0000);
    run("amoadd_w_hi", F_ADD, FW, 64'h120, 64'hABCD_0000_0000_0001, -1, 5, 64'h7FFF_FFFF, 2'b00, 1, 1);
    mem[64'h128] = 64'h0000_0000_FFFF_FFFF;
    exp_q.push_back(64'd1);
    run("amoadd_w_wrap", F_ADD, FW, 64'h128, 64'd2, -1, 5, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1, 1);
    mem[64'h130] = 64'hFFFF_FFFF_FFFF_FFFE;
    exp_q.push_back(64'd3);
    run("amomax_d", F_MAX, FD, 64'h130, 64'd3, -1, 5, 64'hFFFF_FFFF_FFFF_FFFE, 2'b00, 1, 1);
    mem[64'h138] = 64'hFFFF_FFFF_FFFF_FFFE;
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFE);
    run("amomaxu_d", F_MAXU, FD, 64'h138, 64'd3, -1, 5, 64'hFFFF_FFFF_FFFF_FFFE, 2'b00, 1, 1);
    mem[64'h140] = 64'hAAAA_AAAA_1234_5678;
    exp_q.push_back(64'h0000_0000_CAFE_F00D);
    run("amoswap_w", F_SWAP, FW, 64'h140, 64'hFFFF_FFFF_CAFE_F00D, -1, 5, 64'h1234_5678, 2'b00, 1, 1);
    mem[64'h148] = 64'hF0F0; mem[64'h150] = 64'hF0F0; mem[64'h158] = 64'hF0F0;
    exp_q.push_back(64'h0FF0);
    run("amoxor_d", F_XOR, FD, 64'h148, 64'hFF00, -1, 5, 64'hF0F0, 2'b00, 1, 1);
    exp_q.push_back(64'hF000);
    run("amoand_d", F_AND, FD, 64'h150, 64'hFF00, -1, 5, 64'hF0F0, 2'b00, 1, 1);
    exp_q.push_back(64'hFFF0);
    run("amoor_d", F_OR, FD, 64'h158, 64'hFF00, -1, 5, 64'hF0F0, 2'b00, 1, 1);
    mem[64'h160] = 64'h0000_0000_8000_0000;
    exp_q.push_back(64'h0000_0000_7FFF_FFFF);
    run("amomax_w", F_MAX, FW, 64'h160, 64'h7FFF_FFFF, -1, 5, 64'hFFFF_FFFF_8000_0000, 2'b00, 1, 1);

    // LR/SC
    mem[64'h200] = 64'h55;
    run("lr_d", F_LR, FD, 64'h200, 64'd0, -1, 3, 64'h55, 2'b00, 1, 0);
    exp_q.push_back(64'h99);
    run("sc_d_ok", F_SC, FD, 64'h200, 64'h99, -1, 3, 64'd0, 2'b00, 0, 1);
    run("sc_d_again", F_SC, FD, 64'h200, 64'h99, -1, 1, 64'd1, 2'b00, 0, 0);
    mem[64'h300] = 64'h0000_0000_8000_0000;
    run("lr_w", F_LR, FW, 64'h300, 64'd0, -1, 3, 64'hFFFF_FFFF_8000_0000, 2'b00, 1, 0);
    @(negedge clk); resv_clear = 1'b1;
    @(negedge clk); resv_clear = 1'b0;
    run("sc_w_cleared", F_SC, FW, 64'h300, 64'd5, -1, 1, 64'd1, 2'b00, 0, 0);
    run("lr_w2", F_LR, FW, 64'h300, 64'd0, -1, 3, 64'hFFFF_FFFF_8000_0000, 2'b00, 1, 0);
    run("sc_w_other_gran", F_SC, FW, 64'h308, 64'd5, -1, 1, 64'd1, 2'b00, 0, 0);
    run("lr_w3", F_LR, FW, 64'h300, 64'd0, -1, 3, 64'hFFFF_FFFF_8000_0000, 2'b00, 1, 0);
    exp_q.push_back(64'h42);
    run("sc_w_same_gran", F_SC, FW, 64'h304, 64'hFFFF_FFFF_0000_0042, -1, 3, 64'd0, 2'b00, 0, 1);
    run("lr_clear_race", F_LR, FD, 64'h800, 64'd0, 2, 3, 64'd0, 2'b00, 1, 0);
    run("sc_after_race", F_SC, FD, 64'h800, 64'd1, -1, 1, 64'd1, 2'b00, 0, 0);

    // errors: no memory traffic, reservation untouched
    run("err_misalign_w", F_ADD, FW, 64'h102, 64'd1, -1, 1, 64'd0, 2'b10, 0, 0);
    run("err_funct5", 5'b11111, FD, 64'h100, 64'd1, -1, 1, 64'd0, 2'b01, 0, 0);
    run("err_funct3", F_LR, 3'b000, 64'h100, 64'd0, -1, 1, 64'd0, 2'b01, 0, 0);
    run("err_illegal_first", F_ADD, 3'b111, 64'h103, 64'd0, -1, 1, 64'd0, 2'b01, 0, 0);
    run("err_misalign_d", F_SWAP, FD, 64'h104, 64'd1, -1, 1, 64'd0, 2'b10, 0, 0);
    mem[64'h700] = 64'h77;
    run("lr_d_700", F_LR, FD, 64'h700, 64'd0, -1, 3, 64'h77, 2'b00, 1, 0);
    run("sc_misalign", F_SC, FD, 64'h701, 64'd1, -1, 1, 64'd0, 2'b10, 0, 0);
    exp_q.push_back(64'h1234);
    run("sc_after_err", F_SC, FD, 64'h700, 64'h1234, -1, 3, 64'd0, 2'b00, 0, 1);

    // memory stall: 3 not-ready cycles on the read request
    mem[64'h600] = 64'd1;
    stall_req = 3;
    exp_q.push_back(64'd2);
    run("stall_add", F_ADD, FD, 64'h600, 64'd1, -1, 8, 64'd1, 2'b00, 1, 1);
    check("stall_checks", 64'(stall_checks), 64'd3);
    check("stall_stable", 64'(stall_bad), 64'd0);

    // reset while waiting on a read, with the response arriving late
    mem[64'h400] = 64'h44;
    run("lr_d_400", F_LR, FD, 64'h400, 64'd0, -1, 3, 64'h44, 2'b00, 1, 0);
    mem[64'h500] = 64'd9;
    rsp_delay = 3;
    @(negedge clk);
    req_valid = 1'b1; req_funct5 = F_ADD; req_funct3 = FD; req_addr = 64'h500; req_rs2 = 64'd1;
    @(negedge clk);
    req_valid = 1'b0;
    check("pre_rst_rd_req", 64'(dbg_state), 64'd1);
    @(negedge clk);
    check("pre_rst_rd_wait", 64'(dbg_state), 64'd2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_state", 64'(dbg_state), 64'd0);
    check("mid_rst_req_ready", 64'(req_ready), 64'd1);
    check("mid_rst_mem_addr", mem_addr, 64'd0);
    check("mid_rst_mem_wdata", mem_wdata, 64'd0);
    check("mid_rst_rsp_rdata", rsp_rdata, 64'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("late_rsp_ignored_state", 64'(dbg_state), 64'd0);
      check("late_rsp_no_rsp", 64'(rsp_valid), 64'd0);
      check("late_rsp_no_mem", 64'(mem_req_valid), 64'd0);
    end
    rsp_delay = 0;
    run("sc_after_rst", F_SC, FD, 64'h400, 64'd1, -1, 1, 64'd1, 2'b00, 0, 0);

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
